bcd_display_converter: RTL
==========================

Name: bcd_display_converter

Overview:
Multi-channel binary-to-BCD converter for the performance-counter display path. It converts N_CH binary counter values (for example total cycles, conditional-branch count and unconditional-branch count) into packed decimal digits for the seven-segment driver. Conversion is sequential shift-add-3 (double dabble), one bit per clock, one channel at a time, replacing divider-based logic. It adds a start/done handshake, a coherent snapshot across channels, a continuous auto-refresh mode and per-channel overflow saturation.

Parameters:
N_CH, 3, number of binary channels
BIN_W, 32, width of each binary input
DIGITS, 5, decimal digits per channel (4 bits each)

Ports:
clk_n  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-low reset
start  in  1  conversion request, sampled only in IDLE
auto_mode  in  1  1 = re-launch a conversion automatically after every DONE
bin_data  in  N_CH*BIN_W  channel c occupies bits [c*BIN_W +: BIN_W]
bcd_out  out  N_CH*DIGITS*4  channel c at [c*DIGITS*4 +: DIGITS*4]; digit 0 (units) in the LSB nibble
ovf  out  N_CH  per-channel flag: value >= 10^DIGITS, digits saturated
busy  out  1  high from the launch edge until DONE is left
done  out  1  one-cycle pulse when bcd_out/ovf are updated

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; bcd_out=0, ovf=0, busy=0, done=0; snapshot, shift and channel registers cleared. Reset mid-conversion aborts it; no partial result appears on the outputs.
- Launch: in IDLE, when start=1 or auto_mode=1, capture all of bin_data into a snapshot on that edge, set busy=1 and go to LOAD with ch=0. Later changes to bin_data do not affect the running conversion.
- LOAD (1 cycle): shift register = snapshot[ch], BCD accumulator = 0, bit counter = BIN_W, channel ovf bit = 0.
- SHIFT (BIN_W cycles): on each cycle, first add 3 to every BCD nibble that is >= 5. Then shift {accumulator, shift register} left by 1, MSB first. If the MSB of the top digit is 1 before the shift, set the channel ovf bit.
- STORE (1 cycle): write the result into the staging buffer for ch. If the channel ovf bit is set, write all digits as 9 instead. If ch=N_CH-1 go to DONE; otherwise ch+1 and go to LOAD.
- DONE (1 cycle): copy the staging buffer to bcd_out and ovf in one step, so all channels update together. done=1 in this cycle only. Then go to IDLE, where busy=0.
- Latency: done is high N_CH*(BIN_W+2)+1 cycles after the launch edge (103 cycles at the defaults).
- Between DONE updates, bcd_out and ovf hold their previous values.
- start while busy is ignored. It is not queued.
- auto_mode=1: IDLE lasts exactly one cycle and re-launches on the next edge. Period = N_CH*(BIN_W+2)+2 cycles. Clearing auto_mode mid-conversion lets the current conversion finish and then stop in IDLE.
- start and auto_mode both high in IDLE: a single launch.
- Each nibble is always in 0..9. There is no wrap-around in bcd_out.

Test Plan:
- Reset with rst=0 mid-SHIFT, then release -> bcd_out=0, ovf=0, busy=0, done=0; a later start converts normally.
- bin_data = {0, 100, 12345}, pulse start -> done exactly 103 cycles after the launch edge; ch0 digits 1,2,3,4,5; ch1 digits 0,0,1,0,0; ch2 all 0; ovf=000.
- ch0=99999, ch1=100000, ch2=32'hFFFFFFFF -> ch0 99999 with ovf[0]=0; ch1 and ch2 read 99999 with ovf[1]=ovf[2]=1.
- Change bin_data and pulse start repeatedly while busy -> result matches the snapshot taken at launch; only one done pulse.
- auto_mode=1 with an incrementing input -> done every 104 cycles; bcd_out tracks the snapshots and never shows a mixed-channel update.
- Set auto_mode=0 mid-conversion -> that conversion completes, done fires once, then busy stays 0.

Source files
------------

// File: rtl/bcd_display_converter.sv
// rtl/bcd_display_converter.sv - multi-channel sequential binary-to-BCD converter with coherent snapshot
module bcd_display_converter #(
    parameter int N_CH   = 3,
    parameter int BIN_W  = 32,
    parameter int DIGITS = 5
) (
    input  logic                       clk_n,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       auto_mode,
    input  logic [N_CH*BIN_W-1:0]      bin_data,
    output logic [N_CH*DIGITS*4-1:0]   bcd_out,
    output logic [N_CH-1:0]            ovf,
    output logic                       busy,
    output logic                       done
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [BCD_W-1:0] SAT_VAL  = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;

    logic [N_CH*BIN_W-1:0]     r_snap;
    logic [BIN_W-1:0]          r_shift;
    logic [BCD_W-1:0]          r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [CH_W-1:0]           r_ch;
    logic                      r_ch_ovf;
    logic [N_CH*BCD_W-1:0]     r_stage_bcd;
    logic [N_CH-1:0]           r_stage_ovf;
    logic [N_CH*BCD_W-1:0]     r_bcd_out;
    logic [N_CH-1:0]           r_ovf;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_launch;
    logic [BIN_W-1:0]          w_ch_data;
    logic [BCD_W-1:0]          w_adj;

    // Start and auto-refresh are only honoured while idle; both together give one launch.
    assign w_launch = (r_state == S_IDLE) && (start || auto_mode);

    // State register.
    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: LOAD, BIN_W shifts and STORE per channel, then one DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_LAST) w_next = S_STORE;
            S_STORE: w_next = (r_ch == LAST_CH) ? S_DONE : S_LOAD;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Select the snapshot word of the channel being converted.
    always_comb begin
        w_ch_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_ch_data = r_snap[c*BIN_W +: BIN_W];
            end
        end
    end

    // Add-3 correction on every decimal digit that would reach 10 or more once doubled.
    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[d*4 +: 4] >= 4'd5) begin
                w_adj[d*4 +: 4] = r_acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Datapath: snapshot capture, double-dabble shifting, staging and the coherent output update.
    always_ff @(posedge clk_n or negedge rst) begin
        if (!rst) begin
            r_snap      <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ch        <= '0;
            r_ch_ovf    <= 1'b0;
            r_stage_bcd <= '0;
            r_stage_ovf <= '0;
            r_bcd_out   <= '0;
            r_ovf       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_snap <= bin_data;
                        r_busy <= 1'b1;
                        r_ch   <= '0;
                    end
                end
                S_LOAD: begin
                    r_shift  <= w_ch_data;
                    r_acc    <= '0;
                    r_cnt    <= CNT_INIT;
                    r_ch_ovf <= 1'b0;
                end
                S_SHIFT: begin
                    // A set top-digit MSB after correction means the value no longer fits in DIGITS.
                    if (w_adj[BCD_W-1]) begin
                        r_ch_ovf <= 1'b1;
                    end
                    r_acc   <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
                    r_shift <= {r_shift[BIN_W-2:0], 1'b0};
                    r_cnt   <= r_cnt - CNT_LAST;
                end
                S_STORE: begin
                    for (int c = 0; c < N_CH; c++) begin
                        if (r_ch == CH_W'(c)) begin
                            r_stage_bcd[c*BCD_W +: BCD_W] <= r_ch_ovf ? SAT_VAL : r_acc;
                            r_stage_ovf[c]                <= r_ch_ovf;
                        end
                    end
                    if (r_ch != LAST_CH) begin
                        r_ch <= r_ch + CH_W'(1);
                    end
                end
                S_DONE: begin
                    r_bcd_out <= r_stage_bcd;
                    r_ovf     <= r_stage_ovf;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bcd_out = r_bcd_out;
    assign ovf     = r_ovf;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
